// File: rtl/mem_pkg.sv
// Shared types and defaults for the unified instruction/data memory controller.
package mem_pkg;

  typedef enum logic [0:0] {
    StClear,
    StIdle
  } state_e;

  localparam int unsigned ReadLatMin = 1;
  localparam int unsigned ReadLatMax = 2;

  localparam logic [31:0] DefaultBootWord = 32'hf0011800;
  localparam logic [31:0] DefaultFillWord = 32'h0000_0000;

endpackage

// File: rtl/mem_byte_ram.sv
// Bare single-port array with per-byte write enables and a registered read port.
module mem_byte_ram #(
  parameter int unsigned DataW = 32,
  parameter int unsigned Depth = 32,
  parameter int unsigned AddrW = 5
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic               re_i,
  input  logic [AddrW-1:0]   addr_i,
  input  logic [DataW-1:0]   wdata_i,
  input  logic [DataW/8-1:0] be_i,
  output logic [DataW-1:0]   rdata_o
);

  localparam int unsigned NumBytes = DataW / 8;

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned i = 0; i < NumBytes; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/unified_mem_ctrl.sv
// Unified instruction/data memory: reset-time clear sequencer, req/ready handshake,
// range check and a 1- or 2-cycle read pipeline around a byte-writable array.
module unified_mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned     DATA_W    = 32,
  parameter int unsigned     ADDR_W    = 6,
  parameter int unsigned     DEPTH     = 32,
  parameter int unsigned     READ_LAT  = ReadLatMin,
  parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(DefaultFillWord),
  parameter logic [DATA_W-1:0] BOOT_WORD = DATA_W'(DefaultBootWord)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  output logic                err,
  output logic                init_done
);

  localparam int unsigned RamAw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [RamAw-1:0] LastIdx = RamAw'(DEPTH - 1);
  localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

  state_e           state_q, state_d;
  logic [RamAw-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             init_done_q, init_done_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    init_done_d = init_done_q;
    case (state_q)
      StClear: begin
        if (cnt_q == LastIdx) begin
          state_d     = StIdle;
          ready_d     = 1'b1;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + RamAw'(1);
        end
      end
      StIdle:  state_d = StIdle;
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StClear;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      init_done_q <= init_done_d;
    end
  end

  logic accept, rd_acc, wr_acc, in_range;

  assign accept   = req & ready_q;
  assign rd_acc   = accept & ~we;
  assign wr_acc   = accept & we;
  assign in_range = ({1'b0, addr} < DepthLim);

  logic                ram_we, ram_re;
  logic [RamAw-1:0]    ram_addr;
  logic [DATA_W-1:0]   ram_wdata, ram_rdata;
  logic [DATA_W/8-1:0] ram_be;

  // The clear sequencer owns the port until the array holds a defined image.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = addr[RamAw-1:0];
    ram_wdata = wdata;
    ram_be    = be;
    if (state_q == StClear) begin
      ram_we    = 1'b1;
      ram_addr  = cnt_q;
      ram_be    = '1;
      ram_wdata = (cnt_q == '0) ? BOOT_WORD : FILL_WORD;
    end else begin
      ram_we = wr_acc & in_range;
      ram_re = rd_acc & in_range;
    end
  end

  mem_byte_ram #(
    .DataW(DATA_W),
    .Depth(DEPTH),
    .AddrW(RamAw)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .be_i   (ram_be),
    .rdata_o(ram_rdata)
  );

  logic              rd1_q, rd1_d;
  logic              rd_oor1_q, rd_oor1_d;
  logic              wr_err1_q, wr_err1_d;
  logic              rvalid2_q, rvalid2_d;
  logic              rd_err2_q, rd_err2_d;
  logic [DATA_W-1:0] rdata_hold_q, rdata_hold_d;
  logic [DATA_W-1:0] rd_data1;

  always_comb begin
    rd1_d        = rd_acc;
    rd_oor1_d    = rd_acc & ~in_range;
    wr_err1_d    = wr_acc & ~in_range;
    rd_data1     = rd_oor1_q ? '0 : ram_rdata;
    rvalid2_d    = rd1_q;
    rd_err2_d    = rd1_q & rd_oor1_q;
    rdata_hold_d = rd1_q ? rd_data1 : rdata_hold_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd1_q        <= 1'b0;
      rd_oor1_q    <= 1'b0;
      wr_err1_q    <= 1'b0;
      rvalid2_q    <= 1'b0;
      rd_err2_q    <= 1'b0;
      rdata_hold_q <= '0;
    end else begin
      rd1_q        <= rd1_d;
      rd_oor1_q    <= rd_oor1_d;
      wr_err1_q    <= wr_err1_d;
      rvalid2_q    <= rvalid2_d;
      rd_err2_q    <= rd_err2_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

  // Write errors always report one cycle after acceptance, independent of read latency.
  always_comb begin
    ready     = ready_q;
    init_done = init_done_q;
    if (READ_LAT == ReadLatMax) begin
      rvalid = rvalid2_q;
      err    = rd_err2_q | wr_err1_q;
      rdata  = rdata_hold_q;
    end else begin
      rvalid = rd1_q;
      err    = rd_oor1_q | wr_err1_q;
      rdata  = rd1_q ? rd_data1 : rdata_hold_q;
    end
  end

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Bench for unified_mem_ctrl: three configurations driven in lockstep, reads and
// error strobes checked against a reference model through per-instance scoreboards.
module tb_unified_mem_ctrl;

  typedef struct {
    int          cyc;
    logic        rd;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;

  logic [2:0]  ready_v, rvalid_v, err_v, init_v;
  logic [31:0] rdata_v [3];

  int          cyc;
  int          errors;
  int          checks;
  int          lat_a [3];
  int          dep_a [3];
  exp_t        exp_q [3][$];
  logic [31:0] mdl [3][32];

  unified_mem_ctrl u_dut_l1 (
    .clk(clk), .reset_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready_v[0]), .rdata(rdata_v[0]), .rvalid(rvalid_v[0]), .err(err_v[0]),
    .init_done(init_v[0])
  );

  unified_mem_ctrl #(.READ_LAT(2)) u_dut_l2 (
    .clk(clk), .reset_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready_v[1]), .rdata(rdata_v[1]), .rvalid(rvalid_v[1]), .err(err_v[1]),
    .init_done(init_v[1])
  );

  unified_mem_ctrl #(.DEPTH(24), .ADDR_W(5)) u_dut_d24 (
    .clk(clk), .reset_n(rst_n), .req(req), .we(we), .addr(addr[4:0]), .wdata(wdata),
    .be(be), .ready(ready_v[2]), .rdata(rdata_v[2]), .rvalid(rvalid_v[2]), .err(err_v[2]),
    .init_done(init_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Drive one access for the coming edge and record what each instance must produce.
  task automatic issue(input logic w, input logic [5:0] a, input logic [31:0] d,
                       input logic [3:0] b);
    exp_t e;
    logic [4:0] ai;
    ai    = a[4:0];
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    be    = b;
    for (int k = 0; k < 3; k++) begin
      if (int'(a) >= dep_a[k]) begin
        e.rd   = ~w;
        e.err  = 1'b1;
        e.data = 32'h0;
        e.cyc  = w ? cyc + 1 : cyc + lat_a[k];
        exp_q[k].push_back(e);
      end else if (w) begin
        for (int i = 0; i < 4; i++) begin
          if (b[i]) mdl[k][ai][8*i +: 8] = d[8*i +: 8];
        end
      end else begin
        e.rd   = 1'b1;
        e.err  = 1'b0;
        e.data = mdl[k][ai];
        e.cyc  = cyc + lat_a[k];
        exp_q[k].push_back(e);
      end
    end
    @(posedge clk);
    #1;
    req = 1'b0;
    we  = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int k = 0; k < 3; k++) begin
          if (rvalid_v[k] || err_v[k]) begin
            checks++;
            if (exp_q[k].size() == 0) begin
              errors++;
              $display("FAIL sb_unexpected dut%0d cyc=%0d: got rvalid=%b err=%b rdata=%h, expected no strobe",
                       k, cyc, rvalid_v[k], err_v[k], rdata_v[k]);
            end else begin
              e = exp_q[k].pop_front();
              if (e.cyc != cyc || rvalid_v[k] !== e.rd || err_v[k] !== e.err ||
                  (e.rd && rdata_v[k] !== e.data)) begin
                errors++;
                $display("FAIL sb_strobe dut%0d: got cyc=%0d rvalid=%b err=%b rdata=%h, expected cyc=%0d rvalid=%b err=%b rdata=%h",
                         k, cyc, rvalid_v[k], err_v[k], rdata_v[k], e.cyc, e.rd, e.err, e.data);
              end
            end
          end else if (exp_q[k].size() > 0 && exp_q[k][0].cyc <= cyc) begin
            checks++;
            errors++;
            e = exp_q[k].pop_front();
            $display("FAIL sb_missing dut%0d: got no strobe at cyc=%0d, expected rvalid=%b err=%b rdata=%h at cyc=%0d",
                     k, cyc, e.rd, e.err, e.data, e.cyc);
          end
        end
      end
    end
  endtask

  task automatic test_reset(input int mid_clear);
    int rdy_at [3];
    int init_at [3];
    req   = 1'b0;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_q[k].delete();
      for (int w = 0; w < 32; w++) mdl[k][w] = (w == 0) ? 32'hf0011800 : 32'h0;
    end
    #2;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ready_v[k], rvalid_v[k], err_v[k], init_v[k]} !== 4'b0000 || rdata_v[k] !== 32'h0)
      begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got ready=%b rvalid=%b err=%b init_done=%b rdata=%h, expected all 0",
                 k, ready_v[k], rvalid_v[k], err_v[k], init_v[k], rdata_v[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    if (mid_clear > 0) begin
      repeat (mid_clear) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ready_v[k] !== 1'b0 || init_v[k] !== 1'b0) begin
          errors++;
          $display("FAIL midclear_reset dut%0d: got ready=%b init_done=%b, expected 0 0",
                   k, ready_v[k], init_v[k]);
        end
      end
      @(negedge clk);
      rst_n = 1'b1;
    end
    for (int k = 0; k < 3; k++) begin
      rdy_at[k]  = 0;
      init_at[k] = 0;
    end
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (ready_v[k] && rdy_at[k] == 0) rdy_at[k] = n;
        if (init_v[k] && init_at[k] == 0) init_at[k] = n;
      end
      if (rdy_at[0] != 0 && rdy_at[1] != 0 && rdy_at[2] != 0) break;
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdy_at[k] != dep_a[k] || init_at[k] != dep_a[k]) begin
        errors++;
        $display("FAIL clear_length dut%0d: got ready at %0d init_done at %0d, expected both at %0d",
                 k, rdy_at[k], init_at[k], dep_a[k]);
      end
    end
  endtask

  task automatic test_boot_image();
    issue(1'b0, 6'd0, 32'h0, 4'h0);
    issue(1'b0, 6'd5, 32'h0, 4'h0);
    issue(1'b0, 6'd31, 32'h0, 4'h0);
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (exp_q[k].size() != 0) begin
        errors++;
        $display("FAIL boot_drain dut%0d: got %0d pending, expected 0", k, exp_q[k].size());
      end
    end
  endtask

  task automatic test_byte_enable();
    issue(1'b1, 6'd3, 32'hDEADBEEF, 4'b1111);
    issue(1'b1, 6'd3, 32'h000000AA, 4'b0001);
    issue(1'b0, 6'd3, 32'h0, 4'h0);
    issue(1'b1, 6'd3, 32'hFFFFFFFF, 4'b0000);
    issue(1'b1, 6'd4, 32'h11223344, 4'b1111);
    issue(1'b1, 6'd4, 32'hA5C3E100, 4'b0110);
    issue(1'b0, 6'd3, 32'h0, 4'h0);
    issue(1'b0, 6'd4, 32'h0, 4'h0);
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (exp_q[k].size() != 0) begin
        errors++;
        $display("FAIL be_drain dut%0d: got %0d pending, expected 0", k, exp_q[k].size());
      end
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 6'd1, 32'd11, 4'hF);
    issue(1'b1, 6'd2, 32'd22, 4'hF);
    issue(1'b1, 6'd3, 32'd33, 4'hF);
    issue(1'b0, 6'd1, 32'h0, 4'h0);
    issue(1'b0, 6'd2, 32'h0, 4'h0);
    issue(1'b0, 6'd3, 32'h0, 4'h0);
    issue(1'b1, 6'd7, 32'h12345678, 4'hF);
    issue(1'b0, 6'd7, 32'h0, 4'h0);
    issue(1'b1, 6'd7, 32'h0BADF00D, 4'b1100);
    issue(1'b0, 6'd7, 32'h0, 4'h0);
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (exp_q[k].size() != 0) begin
        errors++;
        $display("FAIL b2b_drain dut%0d: got %0d pending, expected 0", k, exp_q[k].size());
      end
    end
  endtask

  task automatic test_out_of_range();
    issue(1'b0, 6'd30, 32'h0, 4'h0);
    issue(1'b1, 6'd25, 32'h00000055, 4'hF);
    issue(1'b0, 6'd25, 32'h0, 4'h0);
    issue(1'b1, 6'd23, 32'h00000077, 4'hF);
    issue(1'b0, 6'd23, 32'h0, 4'h0);
    issue(1'b0, 6'd24, 32'h0, 4'h0);
    issue(1'b0, 6'd1, 32'h0, 4'h0);
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (exp_q[k].size() != 0) begin
        errors++;
        $display("FAIL oor_drain dut%0d: got %0d pending, expected 0", k, exp_q[k].size());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    be    = '0;
    lat_a = '{1, 2, 1};
    dep_a = '{32, 32, 24};
    fork
      monitor();
    join_none
    test_reset(0);
    test_boot_image();
    test_byte_enable();
    test_back_to_back();
    test_out_of_range();
    test_reset(10);
    test_boot_image();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unified_mem_ctrl.md
Name: unified_mem_ctrl

Overview:
Parametrised single-port unified instruction/data memory for the multi-cycle CPU. It replaces the fixed 32x32 store with configurable width, depth and read latency. It adds byte-enabled writes, a req/ready handshake with a read-valid strobe, and an out-of-range error flag. A reset-time clear sequencer fills the array with FILL_WORD and writes BOOT_WORD at word 0, so the CPU sees a defined image after every reset.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 8.
ADDR_W, 6, word-address width.
DEPTH, 32, number of words; DEPTH <= 2**ADDR_W.
READ_LAT, 1, cycles from an accepted read to rvalid; legal values are 1 or 2.
FILL_WORD, 0, value written to words 1..DEPTH-1 during the clear sequence.
BOOT_WORD, 32'hf0011800, value written to word 0 during the clear sequence; sized to DATA_W.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
req  input  1  access request; sampled when ready=1.
we  input  1  1 = write, 0 = read; qualified by req.
addr  input  ADDR_W  word address.
wdata  input  DATA_W  write data.
be  input  DATA_W/8  byte enables; bit i covers wdata[8i+7:8i].
ready  output  1  block can accept a request this cycle.
rdata  output  DATA_W  read data; valid only while rvalid=1.
rvalid  output  1  one-cycle strobe marking rdata valid.
err  output  1  one-cycle strobe: the accepted access addressed a word >= DEPTH.
init_done  output  1  clear sequence complete; stays high until the next reset.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - ready=0, rvalid=0, rdata=0, err=0, init_done=0.
  - FSM goes to CLEAR and the clear counter goes to 0.
  - Array contents are not reset directly; the CLEAR state overwrites them.
- CLEAR state:
  - Counter value c runs 0..DEPTH-1, one word per cycle.
  - Writes BOOT_WORD when c=0, FILL_WORD otherwise.
  - ready=0 throughout; req is ignored.
  - After writing word DEPTH-1: go to IDLE, set init_done=1 and ready=1 on the next cycle.
  - Total: DEPTH cycles after reset release.
- Reset asserted mid-CLEAR or mid-IDLE: immediately return to CLEAR with counter 0. In-flight reads are dropped; no rvalid is produced for them.
- IDLE state:
  - ready=1 continuously.
  - One access accepted per cycle when req=1; back-to-back accesses are allowed with no bubbles.
- Write (req=1, we=1):
  - Applied at the accepting edge, only for bytes with be[i]=1; other bytes keep their value.
  - be=0 is accepted as a no-op.
  - Writes produce no rvalid.
- Read (req=1, we=0):
  - READ_LAT=1: rdata/rvalid appear the cycle after acceptance.
  - READ_LAT=2: one extra output register stage. Reads still pipeline, one result per cycle.
  - A read issued the cycle after a write to the same address returns the newly written data.
- Out of range (addr >= DEPTH):
  - Write: discarded; err pulses the cycle after acceptance.
  - Read: rdata=0, with rvalid and err pulsed together at the normal READ_LAT.
- Between strobes:
  - rdata holds its last value.
  - rvalid and err return to 0 the cycle after their pulse.
- Simultaneous events:
  - Only one access per cycle is possible (single port), so there are no read/write collisions.
  - An accepted write never shifts pending read strobes.
- Address width: addr is used at full ADDR_W for the range check. When DEPTH = 2**ADDR_W, err is never set.

Decomposition:
- Shared package mem_pkg:
  - state enum {CLEAR, IDLE}.
  - READ_LAT legal-value constants.
  - Default BOOT_WORD/FILL_WORD constants.
- One natural sub-module, mem_byte_ram: a bare single-port, byte-writable array with a registered read. The top level holds the clear FSM, range check, handshake and latency pipeline.

Test Plan:
- Reset then wait: ready=0 for exactly 32 cycles after reset_n rises. Then init_done=1. Reading word 0 returns 32'hf0011800 and word 5 returns 0.
- Write 32'hDEADBEEF to addr 3 with be=4'b1111, then write 32'h000000AA with be=4'b0001. A read of addr 3 returns 32'hDEADBEAA with rvalid exactly 1 cycle later (READ_LAT=1).
- READ_LAT=2, back-to-back reads of addrs 1, 2, 3 holding 11, 22, 33: rvalid high on cycles +2, +3, +4 with rdata 11, 22, 33 in order.
- DEPTH=24, ADDR_W=5: read of addr 30 gives rvalid=1, err=1, rdata=0. Write of addr 25 gives err=1 and leaves the array unchanged.
- Assert reset_n=0 at cycle 10 of CLEAR, release: init_done rises exactly DEPTH cycles after release.
- Write addr 7 = 32'h12345678, then a read of addr 7 on the next cycle: returns 32'h12345678.
